// File: rtl/tqvp_bus_sequencer_pkg.sv
// Shared definitions for the TinyQV peripheral bus sequencer: size codes,
// FSM states, the queued command record and the read-data masking helper.
package tqvp_bus_sequencer_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_IDLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Read data is zero-extended to 32 bits according to the transfer size.
  function automatic logic [31:0] mask_to_size(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] result;
    case (size)
      SZ_BYTE: result = {24'h0, data[7:0]};
      SZ_HALF: result = {16'h0, data[15:0]};
      SZ_WORD: result = data;
      default: result = 32'h0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/tqvp_bus_sequencer_if.sv
// Command and response channels between a requester (master) and the
// bus sequencer (slave).
interface tqvp_bus_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_timeout;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout, rsp_err
  );

endinterface

// File: rtl/tqvp_cmd_fifo.sv
// Synchronous command FIFO. A simultaneous push and pop succeeds even when
// full (slot is recycled) or empty (write data bypasses to the read port).
module tqvp_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && (!o_empty || i_push);
  assign o_rdata   = o_empty ? i_wdata : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tqvp_bus_sequencer.sv
// Queues peripheral commands and plays them one at a time onto the TinyQV
// peripheral bus, returning one response per command; also latches user IRQs.
module tqvp_bus_sequencer
  import tqvp_bus_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tqvp_bus_sequencer_if.slave        s_bus,
  output logic [5:0]                 address,
  output logic [31:0]                data_in,
  output logic [1:0]                 data_write_n,
  output logic [1:0]                 data_read_n,
  input  logic [31:0]                data_out,
  input  logic                       data_ready,
  input  logic                       user_interrupt,
  output logic                       irq_pending,
  input  logic                       irq_clear,
  output logic                       busy
);

  localparam int             CW        = 10;
  localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);

  state_e        r_state;
  state_e        w_next_state;
  cmd_t          w_fifo_wdata;
  cmd_t          w_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_rd_done;
  logic          w_rd_expire;
  logic          w_rsp_done;

  logic [5:0]    r_address;
  logic [31:0]   r_data_in;
  logic [1:0]    r_size;
  logic [CW-1:0] r_wait_cnt;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_write;
  logic          r_rsp_timeout;
  logic          r_rsp_err;
  logic          r_irq_prev;
  logic          r_irq_pending;

  assign w_fifo_wdata = '{write: s_bus.cmd_write, size: s_bus.cmd_size,
                          addr: s_bus.cmd_addr, wdata: s_bus.cmd_wdata};
  assign w_push       = s_bus.cmd_valid && !w_fifo_full;

  tqvp_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal gets a default first, so no path can leave one unassigned (latch).
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_rd_done    = 1'b0;
    w_rd_expire  = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
          if (w_head.size == SZ_IDLE) begin
            w_next_state = ST_RESP;
          end else if (w_head.write) begin
            w_next_state = ST_WRITE;
          end else begin
            w_next_state = ST_READ_WAIT;
          end
        end
      end
      ST_WRITE: begin
        w_next_state = ST_RESP;
      end
      ST_READ_WAIT: begin
        if (data_ready) begin
          w_rd_done    = 1'b1;
          w_next_state = ST_RESP;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_rd_expire  = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (s_bus.rsp_ready) begin
          w_rsp_done   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register, so they can never overlap.
  assign data_write_n = (r_state == ST_WRITE)     ? r_size : SZ_IDLE;
  assign data_read_n  = (r_state == ST_READ_WAIT) ? r_size : SZ_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_address     <= '0;
      r_data_in     <= '0;
      r_size        <= SZ_IDLE;
      r_wait_cnt    <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_write   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      if (w_pop) begin
        r_address <= w_head.addr;
        r_data_in <= w_head.wdata;
        r_size    <= w_head.size;
      end

      if ((r_state == ST_READ_WAIT) && (w_next_state == ST_READ_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_pop && (w_head.size == SZ_IDLE)) begin
        r_rsp_err   <= 1'b1;
        r_rsp_write <= w_head.write;
        r_rsp_rdata <= '0;
      end else if (r_state == ST_WRITE) begin
        r_rsp_write <= 1'b1;
        r_rsp_rdata <= '0;
      end else if (w_rd_done) begin
        r_rsp_write <= 1'b0;
        r_rsp_rdata <= mask_to_size(r_size, data_out);
      end else if (w_rd_expire) begin
        r_rsp_write   <= 1'b0;
        r_rsp_timeout <= 1'b1;
        r_rsp_rdata   <= '0;
      end else if (w_rsp_done) begin
        r_rsp_write   <= 1'b0;
        r_rsp_timeout <= 1'b0;
        r_rsp_err     <= 1'b0;
        r_rsp_rdata   <= '0;
      end
    end
  end

  // A new rising edge outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_prev    <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      r_irq_prev    <= user_interrupt;
      r_irq_pending <= (user_interrupt && !r_irq_prev) || (r_irq_pending && !irq_clear);
    end
  end

  assign s_bus.cmd_ready   = !w_fifo_full;
  assign s_bus.rsp_valid   = (r_state == ST_RESP);
  assign s_bus.rsp_rdata   = r_rsp_rdata;
  assign s_bus.rsp_write   = r_rsp_write;
  assign s_bus.rsp_timeout = r_rsp_timeout;
  assign s_bus.rsp_err     = r_rsp_err;

  assign address     = r_address;
  assign data_in     = r_data_in;
  assign irq_pending = r_irq_pending;
  assign busy        = !w_fifo_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_tqvp_bus_sequencer.sv
// Directed bench for tqvp_bus_sequencer (DEPTH=4, TIMEOUT=8) with
// hand-computed expectations.
module tb_tqvp_bus_sequencer;
  import tqvp_bus_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic        irq_pending;
  logic        irq_clear;
  logic        busy;

  int   n_checks = 0;
  int   n_fail = 0;
  logic bus_clash = 1'b0;

  tqvp_bus_sequencer_if u_if ();

  tqvp_bus_sequencer #(
    .DEPTH   (4),
    .TIMEOUT (8)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_bus          (u_if.slave),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt),
    .irq_pending    (irq_pending),
    .irq_clear      (irq_clear),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_write_n != SZ_IDLE && data_read_n != SZ_IDLE) bus_clash = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [1:0] sz, input logic [5:0] a, input logic [31:0] d);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_write = wr;
    u_if.cmd_size  = sz;
    u_if.cmd_addr  = a;
    u_if.cmd_wdata = d;
    tick();
    u_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_bus(input string tag);
    int n = 0;
    while (data_write_n == SZ_IDLE && data_read_n == SZ_IDLE && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_bus_start"}, 32'(n < 20), 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (u_if.rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rsp_seen"}, 32'(n < 20), 32'd1);
  endtask

  task automatic ack(input string tag);
    u_if.rsp_ready = 1'b1;
    tick();
    u_if.rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(u_if.rsp_valid), 32'd0);
  endtask

  initial begin
    int   n;
    int   k;
    logic quiet;
    logic accept;
    logic [5:0] seen [5];

    u_if.cmd_valid = 1'b0;
    u_if.cmd_write = 1'b0;
    u_if.cmd_size  = SZ_BYTE;
    u_if.cmd_addr  = '0;
    u_if.cmd_wdata = '0;
    u_if.rsp_ready = 1'b0;
    data_out       = '0;
    data_ready     = 1'b0;
    user_interrupt = 1'b0;
    irq_clear      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_write_n", 32'(data_write_n), 32'd3);
    check("rst_read_n", 32'(data_read_n), 32'd3);
    check("rst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    check("rst_rsp_rdata", u_if.rsp_rdata, 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_data_in", data_in, 32'd0);
    check("rst_irq", 32'(irq_pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_cmd_ready", 32'(u_if.cmd_ready), 32'd1);

    // data_ready outside READ_WAIT is ignored
    data_ready = 1'b1;
    tick();
    tick();
    check("stray_ready_rsp", 32'(u_if.rsp_valid), 32'd0);
    check("stray_ready_busy", 32'(busy), 32'd0);
    data_ready = 1'b0;

    // 8-bit write
    push(1'b1, SZ_BYTE, 6'h05, 32'h0000_00A5);
    wait_bus("wr8");
    check("wr8_write_n", 32'(data_write_n), 32'd0);
    check("wr8_read_n", 32'(data_read_n), 32'd3);
    check("wr8_address", 32'(address), 32'h05);
    check("wr8_data_in", data_in, 32'hA5);
    tick();
    check("wr8_one_cycle", 32'(data_write_n), 32'd3);
    wait_rsp("wr8");
    check("wr8_rsp_write", 32'(u_if.rsp_write), 32'd1);
    check("wr8_rsp_err", 32'(u_if.rsp_err), 32'd0);
    check("wr8_rsp_rdata", u_if.rsp_rdata, 32'd0);
    ack("wr8");

    // 16-bit read, data_ready on the third wait cycle
    data_out = 32'hDEAD_BEEF;
    push(1'b0, SZ_HALF, 6'h10, 32'h0);
    wait_bus("rd16");
    check("rd16_address", 32'(address), 32'h10);
    check("rd16_cyc1", 32'(data_read_n), 32'd1);
    tick();
    check("rd16_cyc2", 32'(data_read_n), 32'd1);
    tick();
    check("rd16_cyc3", 32'(data_read_n), 32'd1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("rd16_release", 32'(data_read_n), 32'd3);
    check("rd16_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
    check("rd16_rdata", u_if.rsp_rdata, 32'h0000_BEEF);
    check("rd16_rsp_write", 32'(u_if.rsp_write), 32'd0);
    check("rd16_timeout", 32'(u_if.rsp_timeout), 32'd0);
    ack("rd16");

    // 32-bit read with data_ready tied high
    data_out   = 32'h1234_5678;
    data_ready = 1'b1;
    push(1'b0, SZ_WORD, 6'h2A, 32'h0);
    wait_bus("rd32");
    check("rd32_read_n", 32'(data_read_n), 32'd2);
    tick();
    check("rd32_one_cycle", 32'(data_read_n), 32'd3);
    check("rd32_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
    check("rd32_rdata", u_if.rsp_rdata, 32'h1234_5678);
    data_ready = 1'b0;
    ack("rd32");

    // 8-bit read zero-extends
    data_out = 32'hCAFE_F00D;
    push(1'b0, SZ_BYTE, 6'h3F, 32'h0);
    wait_bus("rd8");
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("rd8_rdata", u_if.rsp_rdata, 32'h0000_000D);
    ack("rd8");

    // Timeout after 8 wait cycles
    push(1'b0, SZ_WORD, 6'h07, 32'h0);
    wait_bus("to");
    n = 0;
    while (data_read_n == SZ_WORD && n < 50) begin
      n++;
      tick();
    end
    check("to_cycles", 32'(n), 32'd8);
    check("to_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
    check("to_flag", 32'(u_if.rsp_timeout), 32'd1);
    check("to_rdata", u_if.rsp_rdata, 32'd0);
    check("to_err", 32'(u_if.rsp_err), 32'd0);
    ack("to");

    // Illegal size: error response, no bus activity
    push(1'b1, SZ_IDLE, 6'h01, 32'hFFFF_FFFF);
    quiet = 1'b1;
    n = 0;
    while (u_if.rsp_valid !== 1'b1 && n < 20) begin
      if (data_write_n != SZ_IDLE || data_read_n != SZ_IDLE) quiet = 1'b0;
      tick();
      n++;
    end
    if (data_write_n != SZ_IDLE || data_read_n != SZ_IDLE) quiet = 1'b0;
    check("err_rsp_seen", 32'(n < 20), 32'd1);
    check("err_flag", 32'(u_if.rsp_err), 32'd1);
    check("err_rdata", u_if.rsp_rdata, 32'd0);
    check("err_timeout", 32'(u_if.rsp_timeout), 32'd0);
    check("err_no_bus", 32'(quiet), 32'd1);

    // FIFO fills while the response is held
    for (int i = 0; i < 4; i++) begin
      push(1'b1, SZ_WORD, 6'(6'h21 + i), 32'(32'h100 + i));
      check($sformatf("fill%0d_cmd_ready", i), 32'(u_if.cmd_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    u_if.cmd_valid = 1'b1;
    u_if.cmd_addr  = 6'h25;
    u_if.cmd_wdata = 32'h104;
    tick();
    check("full_refuse", 32'(u_if.cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);

    // Drain; the held 5th command gets in once a slot frees
    u_if.rsp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 60 && k < 5; c++) begin
      if (data_write_n != SZ_IDLE) begin
        seen[k] = address;
        k++;
      end
      accept = u_if.cmd_valid && u_if.cmd_ready;
      tick();
      if (accept) u_if.cmd_valid = 1'b0;
    end
    check("drain_count", 32'(k), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_addr%0d", i), 32'(seen[i]), 32'(33 + i));
    end
    repeat (3) tick();
    u_if.rsp_ready = 1'b0;
    check("drain_idle", 32'(busy), 32'd0);

    // Reset during READ_WAIT discards everything
    push(1'b0, SZ_HALF, 6'h12, 32'h0);
    wait_bus("rrst");
    push(1'b1, SZ_BYTE, 6'h13, 32'h55);
    tick();
    check("rrst_in_read", 32'(data_read_n), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rrst_read_n", 32'(data_read_n), 32'd3);
    check("rrst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    check("rrst_busy", 32'(busy), 32'd0);
    check("rrst_address", 32'(address), 32'd0);
    tick();
    rst_n = 1'b1;
    check("rrst_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (data_write_n != SZ_IDLE || data_read_n != SZ_IDLE || u_if.rsp_valid) quiet = 1'b0;
    end
    check("rrst_discard", 32'(quiet), 32'd1);

    // Interrupt edge detect and clear
    user_interrupt = 1'b1;
    tick();
    check("irq_set", 32'(irq_pending), 32'd1);
    user_interrupt = 1'b0;
    tick();
    check("irq_sticky", 32'(irq_pending), 32'd1);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("irq_clear", 32'(irq_pending), 32'd0);
    user_interrupt = 1'b1;
    irq_clear      = 1'b1;
    tick();
    check("irq_set_wins", 32'(irq_pending), 32'd1);
    tick();
    check("irq_level_no_set", 32'(irq_pending), 32'd0);
    irq_clear      = 1'b0;
    user_interrupt = 1'b0;

    check("no_bus_clash", 32'(bus_clash), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
